timer_digit_register: RTL and testbench

Timer digit register for the microwave datapath. It consumes the `BCD`/`loadn`/`pgt_1Hz` stream produced by `control_input`, shifts keyed digits into a 4-digit MM:SS register, and counts the register down once per `pgt_1Hz` tick while cooking. It drives the display digits and a one-cycle `done` pulse to the magnetron/door control.

---
 rtl/timer_digit_register.sv | 138 +++++++++++++
 tb/tb_timer_digit_register.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/timer_digit_register.sv
// MM:SS timer digit register: shifts keyed BCD digits in while idle and counts
// down once per 1 Hz tick while running, pulsing done on reaching 00:00.
module timer_digit_register (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] BCD,
  input  logic       loadn,
  input  logic       pgt_1Hz,
  input  logic       start,
  input  logic       stop,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       zero,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] digits_q, digits_d;
  logic        loadn_q;
  logic        running_q, running_d;
  logic        done_q, done_d;
  logic        load_ev_s;
  logic        zero_s;
  logic [15:0] dec_s;

  // BCD countdown with borrow; digits packed as {min_tens, min_ones, sec_tens, sec_ones}.
  // Seconds tens above 5 are never normalised, so keyed 00:99 counts down literally.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [15:0] r;
    r = t;
    if (t[3:0] != 4'd0) begin
      r[3:0] = t[3:0] - 4'd1;
    end else begin
      r[3:0] = 4'd9;
      if (t[7:4] != 4'd0) begin
        r[7:4] = t[7:4] - 4'd1;
      end else begin
        r[7:4] = 4'd5;
        if (t[11:8] != 4'd0) begin
          r[11:8] = t[11:8] - 4'd1;
        end else begin
          r[11:8]  = 4'd9;
          r[15:12] = t[15:12] - 4'd1;
        end
      end
    end
    return r;
  endfunction

  assign load_ev_s = !loadn && loadn_q;
  assign zero_s    = (digits_q == 16'h0000);
  assign dec_s     = bcd_dec(digits_q);

  // Next-state and digit update; stop beats start beats tick beats load.
  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (stop) begin
          digits_d = 16'h0000;
        end else if (start && !zero_s) begin
          state_d = RUN;
        end else if (load_ev_s && (BCD <= 4'd9)) begin
          digits_d = {digits_q[11:0], BCD};
        end else begin
          digits_d = digits_q;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = PAUSED;
        end else if (pgt_1Hz) begin
          digits_d = dec_s;
          if (dec_s == 16'h0000) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = RUN;
        end
      end
      PAUSED: begin
        if (stop) begin
          state_d  = IDLE;
          digits_d = 16'h0000;
        end else if (start) begin
          state_d = RUN;
        end else begin
          state_d = PAUSED;
        end
      end
      default: begin
        state_d  = IDLE;
        digits_d = 16'h0000;
      end
    endcase
    running_d = (state_d == RUN);
  end

  // State, digit and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      digits_q  <= 16'h0000;
      loadn_q   <= 1'b1;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      digits_q  <= digits_d;
      loadn_q   <= loadn;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign sec_ones = digits_q[3:0];
  assign sec_tens = digits_q[7:4];
  assign min_ones = digits_q[11:8];
  assign min_tens = digits_q[15:12];
  assign running  = running_q;
  assign zero     = zero_s;
  assign done     = done_q;

endmodule

// File: tb/tb_timer_digit_register.sv
// Directed bench for timer_digit_register: digit entry, countdown, pause/clear
// and asynchronous reset, all against hand-computed values.
module tb_timer_digit_register;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] BCD = 4'd0;
  logic       loadn = 1'b1;
  logic       pgt_1Hz = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic       running, zero, done;

  int n_checks = 0;
  int n_pass = 0;

  timer_digit_register dut (
    .clock(clock), .reset(reset), .BCD(BCD), .loadn(loadn), .pgt_1Hz(pgt_1Hz),
    .start(start), .stop(stop), .sec_ones(sec_ones), .sec_tens(sec_tens),
    .min_ones(min_ones), .min_tens(min_tens), .running(running), .zero(zero),
    .done(done)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] disp();
    return {min_tens, min_ones, sec_tens, sec_ones};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    BCD = d;
    loadn = 1'b0;
    repeat (3) step();
    loadn = 1'b1;
    step();
  endtask

  task automatic tick();
    pgt_1Hz = 1'b1;
    step();
    pgt_1Hz = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    #12;
    reset = 1'b0;
    step();
    chk("rst_digits", disp(), 16'h0000);
    chk("rst_zero", zero, 1'b1);
    chk("rst_running", running, 1'b0);
    chk("rst_done", done, 1'b0);

    // Held key shifts exactly once
    BCD = 4'd1;
    loadn = 1'b0;
    step();
    chk("shift_first_edge", disp(), 16'h0001);
    step();
    step();
    chk("held_no_repeat", disp(), 16'h0001);
    loadn = 1'b1;
    step();
    press(4'd3);
    press(4'd0);
    chk("load_0130", disp(), 16'h0130);
    chk("load_not_zero", zero, 1'b0);

    pulse_stop();
    chk("idle_stop_clear", disp(), 16'h0000);
    press(4'd0); press(4'd0); press(4'd0); press(4'd2);
    chk("load_0002", disp(), 16'h0002);
    start = 1'b1;
    pgt_1Hz = 1'b1;
    step();
    start = 1'b0;
    pgt_1Hz = 1'b0;
    chk("start_running", running, 1'b1);
    chk("start_no_dec", disp(), 16'h0002);
    tick();
    chk("tick1", disp(), 16'h0001);
    chk("tick1_done", done, 1'b0);
    tick();
    chk("tick2", disp(), 16'h0000);
    chk("tick2_done", done, 1'b1);
    chk("tick2_running", running, 1'b0);
    chk("tick2_zero", zero, 1'b1);
    step();
    chk("done_one_cycle", done, 1'b0);
    tick();
    chk("tick3_digits", disp(), 16'h0000);
    chk("tick3_running", running, 1'b0);
    chk("tick3_done", done, 1'b0);

    press(4'd1); press(4'd0); press(4'd0);
    chk("load_0100", disp(), 16'h0100);
    pulse_start();
    tick();
    chk("borrow_0059", disp(), 16'h0059);
    pulse_stop();
    pulse_stop();
    chk("clear_after_0059", disp(), 16'h0000);
    press(4'd9); press(4'd9);
    chk("load_0099", disp(), 16'h0099);
    pulse_start();
    repeat (40) tick();
    chk("literal_0099_to_0059", disp(), 16'h0059);
    chk("literal_running", running, 1'b1);
    pulse_stop();
    pulse_stop();

    press(4'd4); press(4'd5);
    pulse_start();
    stop = 1'b1;
    pgt_1Hz = 1'b1;
    step();
    stop = 1'b0;
    pgt_1Hz = 1'b0;
    chk("pause_no_dec", disp(), 16'h0045);
    chk("pause_running", running, 1'b0);
    press(4'd7);
    chk("pause_load_ignored", disp(), 16'h0045);
    pulse_start();
    chk("resume_running", running, 1'b1);
    pulse_stop();
    chk("repause_running", running, 1'b0);
    chk("repause_digits", disp(), 16'h0045);
    pulse_stop();
    chk("pause_clear_digits", disp(), 16'h0000);
    chk("pause_clear_done", done, 1'b0);
    chk("pause_clear_running", running, 1'b0);

    pulse_start();
    chk("start_at_zero", running, 1'b0);
    press(4'd12);
    chk("bcd12_ignored_zero", disp(), 16'h0000);
    press(4'd5);
    press(4'd12);
    chk("bcd12_ignored", disp(), 16'h0005);
    pulse_stop();

    press(4'd1); press(4'd1); press(4'd0);
    chk("load_0110", disp(), 16'h0110);
    pulse_start();
    tick();
    chk("run_0109", disp(), 16'h0109);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_digits", disp(), 16'h0000);
    chk("async_rst_running", running, 1'b0);
    chk("async_rst_zero", zero, 1'b1);
    chk("async_rst_done", done, 1'b0);
    #2;
    reset = 1'b0;
    step();
    chk("post_rst_idle", running, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
